fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RV32I pipeline. It replaces the single-register PC plus combinational instruction memory with a prefetch queue talking to a variable-latency instruction memory over a valid/ready request and in-order response interface. It feeds the IF/ID register through a valid/ready pair and supports branch/jump redirect by flushing queued instructions and discarding responses still in flight.

---
 rtl/rv32i_pkg.sv | 8 +
 rtl/fetch_unit_sync_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Constants shared between the fetch front end and the pipeline flush logic.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  // ADDI x0,x0,0: bubble presented whenever no fetched instruction is available.
  localparam logic [31:0] NOP  = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Single-clock FIFO with registered storage; flush has priority over push and pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Prefetching instruction-fetch front end: credit-limited issue to a variable-latency
// in-order memory, registered {pc, instr} queue, redirect with stale-response dropping.
module fetch_unit #(
  parameter int unsigned     XLEN     = rv32i_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = rv32i_pkg::NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]     q_count, tag_count;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic [2*XLEN-1:0] q_rdata;
  logic [XLEN-1:0]   tag_rdata;
  logic              credit_ok, req_fire, rsp_keep;

  // Queue entries plus in-flight requests never exceed DEPTH, so every kept response has a slot.
  assign credit_ok      = ({1'b0, q_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !rst && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt_q == '0);

  assign out_valid = !q_empty;
  assign out_pc    = q_empty ? '0  : q_rdata[2*XLEN-1:XLEN];
  assign out_instr = q_empty ? NOP : q_rdata[XLEN-1:0];

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (req_fire),
    .wdata (fetch_pc_q),
    .pop   (rsp_keep),
    .rdata (tag_rdata),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (rsp_keep),
    .wdata ({tag_rdata, imem_rsp_data}),
    .pop   (out_valid && out_ready),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    if (redirect) begin
      // Everything accepted up to and including this cycle is now stale.
      fetch_pc_d = {redirect_target[XLEN-1:2], 2'b00};
      drop_cnt_d = outstanding_d;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Tags are held only for live (non-dropped) requests.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(rsp_keep && !redirect && q_full));
      assert (!(rsp_keep && tag_empty));
      assert (!(req_fire && tag_full));
      assert (({1'b0, tag_count} + {1'b0, drop_cnt_q}) == {1'b0, outstanding_q});
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for start-up, hand sequences for stall,
// variable latency, redirect, wrap and mid-run reset, with an in-order memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0100),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;

  typedef struct {
    logic        rst;
    logic        oready;
    logic        chk_out;
    logic        chk_addr;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  pend_t       pend[$];
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  bit          rdy_rand = 1'b0;
  bit          rdy_fix = 1'b1;
  int unsigned fires = 0;
  int unsigned beats = 0;
  logic [31:0] exp_pc = 32'h100;
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] memf(logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // First half of a cycle: memory drives its response and ready, outputs settle.
  task automatic half_a();
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memf(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    #1;
  endtask

  // Second half: record accepted requests, check consumed beats, take the edge.
  task automatic half_b();
    pend_t p;
    if (imem_req_valid && imem_req_ready) begin
      p.addr = imem_req_addr;
      p.due  = cyc + $urandom_range(lat_min, lat_max);
      pend.push_back(p);
      fires++;
    end
    if (!rst && !redirect && out_valid && out_ready) begin
      chk("stream_pc", out_pc, exp_pc);
      chk("stream_instr", out_instr, memf(out_pc));
      exp_pc = exp_pc + 32'd4;
      beats++;
    end
    if (rst) exp_pc = 32'h100;
    else if (redirect) exp_pc = {redirect_target[31:2], 2'b00};
    @(posedge clk);
    cyc++;
    if (rst) pend.delete();
    #1;
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) begin
      half_a();
      half_b();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[7];
    int unsigned b0;
    bit          seen;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   32'h13};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   32'h13};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0,   32'h13};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100, memf(32'h100)};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10C, 1'b1, 32'h104, memf(32'h104)};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h110, 1'b1, 32'h108, memf(32'h108)};

    // Start-up from reset with a 1-cycle memory.
    for (int i = 0; i < 7; i++) begin
      rst       = vecs[i].rst;
      out_ready = vecs[i].oready;
      half_a();
      chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
      if (vecs[i].chk_addr) chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      if (vecs[i].chk_out) begin
        chk($sformatf("tbl%0d_out_valid", i), out_valid, vecs[i].e_ov);
        chk($sformatf("tbl%0d_out_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("tbl%0d_out_instr", i), out_instr, vecs[i].e_instr);
      end
      half_b();
    end

    // Stall: issue stops at DEPTH credits, one pop frees exactly one request.
    do_reset();
    out_ready = 1'b0;
    fires = 0;
    step(10);
    chk("stall_fires", fires, 4);
    half_a();
    chk("stall_req_blocked", imem_req_valid, 1'b0);
    half_b();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    half_a();
    chk("stall_resume_valid", imem_req_valid, 1'b1);
    chk("stall_resume_addr", imem_req_addr, 32'h110);
    half_b();
    half_a();
    chk("stall_reblocked", imem_req_valid, 1'b0);
    half_b();
    out_ready = 1'b1;
    step(12);
    chk("stall_progress", 32'(exp_pc >= 32'h114), 1);

    // Variable latency with random memory and decode back-pressure.
    do_reset();
    b0 = beats;
    lat_min = 1; lat_max = 5; rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step(1);
    end
    rdy_rand = 1'b0; rdy_fix = 1'b1; out_ready = 1'b1;
    step(20);
    lat_min = 1; lat_max = 1;
    chk("varlat_beats", 32'((beats - b0) >= 30), 1);

    // Redirect with three requests in flight at L=3.
    do_reset();
    lat_min = 3; lat_max = 3; rdy_fix = 1'b1;
    step(3);
    rdy_fix = 1'b0;
    redirect = 1'b1; redirect_target = 32'h2003;
    half_a();
    chk("redir_pre_out_valid", out_valid, 1'b0);
    half_b();
    redirect = 1'b0; rdy_fix = 1'b1;
    half_a();
    chk("redir_next_valid", imem_req_valid, 1'b1);
    chk("redir_next_addr", imem_req_addr, 32'h2000);
    chk("redir_queue_empty", out_valid, 1'b0);
    half_b();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      half_a();
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        chk("redir_first_pc", out_pc, 32'h2000);
        chk("redir_first_instr", out_instr, memf(32'h2000));
        chk("redir_first_delay", k, 3);
      end
      half_b();
    end
    chk("redir_seen", seen, 1'b1);
    step(6);

    // Redirect in the same cycle as request fire, response and pop.
    do_reset();
    lat_min = 1; lat_max = 1;
    step(6);
    redirect = 1'b1; redirect_target = 32'h3000;
    half_a();
    chk("simul_fire_pre", imem_req_valid, 1'b1);
    chk("simul_pop_pre", out_valid, 1'b1);
    half_b();
    redirect = 1'b0;
    half_a();
    chk("simul_next_addr", imem_req_addr, 32'h3000);
    chk("simul_flushed", out_valid, 1'b0);
    half_b();
    half_a();
    chk("simul_stale_dropped", out_valid, 1'b0);
    half_b();
    half_a();
    chk("simul_first_valid", out_valid, 1'b1);
    chk("simul_first_pc", out_pc, 32'h3000);
    chk("simul_first_instr", out_instr, memf(32'h3000));
    half_b();
    step(4);

    // Address wrap; low target bits are ignored.
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE;
    step(1);
    redirect = 1'b0;
    half_a();
    chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
    half_b();
    half_a();
    chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
    half_b();
    step(6);
    chk("wrap_stream_end", exp_pc, 32'h14);

    // Reset in the middle of streaming.
    rst = 1'b1;
    half_a();
    chk("mrst_req_gated", imem_req_valid, 1'b0);
    half_b();
    rst = 1'b0;
    half_a();
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_out_pc", out_pc, 32'h0);
    chk("mrst_out_instr", out_instr, 32'h13);
    chk("mrst_req_valid", imem_req_valid, 1'b1);
    chk("mrst_req_addr", imem_req_addr, 32'h100);
    half_b();
    step(6);
    chk("mrst_stream_end", exp_pc, 32'h114);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
